// File: rtl/sa_tile_ctrl_if.sv
// Command, operand-read, MAC-enable and drain bundle for the
// systolic-array tile sequencer. The controller connects to the
// slave modport. The host, operand buffers and array use master.
interface sa_tile_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W  = 8
);
  localparam int NDIAG = ROWS + COLS - 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             start;
  logic [K_W-1:0]   k_len;
  logic             ready;
  logic             mac_clr;
  logic             rd_en;
  logic [K_W-1:0]   rd_addr;
  logic [NDIAG-1:0] diag_en;
  logic             out_valid;
  logic [ROW_W-1:0] out_row;
  logic             out_ready;
  logic             done;

  modport master (
    output start, k_len, out_ready,
    input  ready, mac_clr, rd_en, rd_addr, diag_en, out_valid, out_row, done
  );

  modport slave (
    input  start, k_len, out_ready,
    output ready, mac_clr, rd_en, rd_addr, diag_en, out_valid, out_row, done
  );
endinterface

// File: rtl/sa_tile_ctrl.sv
// Tile-pass sequencer for a ROWS x COLS systolic MAC array.
// A pass runs in this order:
//   clear -> K operand reads -> wavefront flush -> row drain -> done.
// Optional macro SA_TILE_CTRL_PERF_EN adds a saturating 32-bit
// perf_cycles counter that counts the cycles spent in the pass.
module sa_tile_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  sa_tile_ctrl_if.slave       bus
`ifdef SA_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);
  localparam int NDIAG   = ROWS + COLS - 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Flush covers the read latency plus the full wavefront travel.
  localparam int FLUSH_N = RD_LAT + NDIAG;
  localparam int FC_W    = $clog2(FLUSH_N + 1);
  // One shift chain: the first RD_LAT taps model the read pipeline.
  // The remaining taps are the per-diagonal enables.
  localparam int SR_W    = RD_LAT + NDIAG - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   r_rd_addr;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [ROW_W-1:0] r_out_row;
  logic [SR_W-1:0]  r_sr;
  logic             w_rd_en;
  logic             w_feed_last;
  logic             w_row_last;
  logic             w_accept;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_rd_en     = (r_state == S_FEED);
  // K is nonzero whenever FEED is entered, so K-1 never underflows here.
  assign w_feed_last = (r_rd_addr == r_k - K_W'(1));
  assign w_row_last  = (r_out_row == ROW_W'(ROWS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = (r_k != '0) ? S_FEED : S_FLUSH;
      S_FEED:  if (w_feed_last) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_flush_cnt == '0) w_state_nxt = S_DRAIN;
      S_DRAIN: if (bus.out_ready && w_row_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the reduction length when a command is accepted
  always_ff @(posedge clk) begin
    if (rst)           r_k <= '0;
    else if (w_accept) r_k <= bus.k_len;
  end

  // Read index: counts through FEED and returns to 0 when FEED is left
  always_ff @(posedge clk) begin
    if (rst)                        r_rd_addr <= '0;
    else if (w_rd_en && !w_feed_last) r_rd_addr <= r_rd_addr + K_W'(1);
    else                            r_rd_addr <= '0;
  end

  // Flush down-counter, loaded on entry so FLUSH lasts exactly FLUSH_N cycles
  always_ff @(posedge clk) begin
    if (rst)
      r_flush_cnt <= '0;
    else if (w_state_nxt == S_FLUSH && r_state != S_FLUSH)
      r_flush_cnt <= FC_W'(FLUSH_N - 1);
    else if (r_state == S_FLUSH && r_flush_cnt != '0)
      r_flush_cnt <= r_flush_cnt - FC_W'(1);
  end

  // Drain row index advances on each accepted beat and wraps to 0 after the last row
  always_ff @(posedge clk) begin
    if (rst)
      r_out_row <= '0;
    else if (r_state == S_DRAIN && bus.out_ready)
      r_out_row <= w_row_last ? '0 : r_out_row + ROW_W'(1);
  end

  // Read-latency pipeline and diagonal wavefront, shifted every cycle
  always_ff @(posedge clk) begin
    if (rst) r_sr <= '0;
    else     r_sr <= SR_W'({r_sr, w_rd_en});
  end

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.mac_clr   = (r_state == S_CLEAR);
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.diag_en   = r_sr[SR_W-1 -: NDIAG];
  assign bus.out_valid = (r_state == S_DRAIN);
  assign bus.out_row   = r_out_row;
  assign bus.done      = (r_state == S_DONE);

`ifdef SA_TILE_CTRL_PERF_EN
  logic [31:0] r_perf;

  // Pass-length counter: zeroed on accept, saturating, frozen while idle
  always_ff @(posedge clk) begin
    if (rst)
      r_perf <= '0;
    else if (r_state == S_IDLE) begin
      if (bus.start) r_perf <= '0;
    end else if (r_perf != 32'hFFFF_FFFF)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`endif
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Self-checking bench for sa_tile_ctrl.
// Each pass is traced cycle by cycle against a timeline model.
// The model gives each cycle its position in the pass:
//   clear, then K reads, then the flush window, then drain beats, then done.
// Diagonal enables are computed arithmetically from the read window.
module tb_sa_tile_ctrl;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int K_W     = 8;
  localparam int RD_LAT  = 1;
  localparam int NDIAG   = ROWS + COLS - 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_N = RD_LAT + ROWS + COLS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_tile_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) bus ();
`ifdef SA_TILE_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  sa_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SA_TILE_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  typedef struct packed {
    logic             ready;
    logic             mac_clr;
    logic             rd_en;
    logic [K_W-1:0]   rd_addr;
    logic [NDIAG-1:0] diag;
    logic             ov;
    logic [ROW_W-1:0] row;
    logic             done;
  } obs_t;

  typedef struct {
    int k;
    int exp_done;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  function automatic obs_t sample();
    obs_t o;
    o.ready   = bus.ready;
    o.mac_clr = bus.mac_clr;
    o.rd_en   = bus.rd_en;
    o.rd_addr = bus.rd_addr;
    o.diag    = bus.diag_en;
    o.ov      = bus.out_valid;
    o.row     = bus.out_row;
    o.done    = bus.done;
    return o;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Entered and left at a negedge inside an IDLE cycle.
  // The start pulse is issued in that same cycle.
  task automatic run_pass(input int k, input int rdy_pct, input int stall_row,
                          input bit noise, output int done_c);
    obs_t e;
    int   row;
    int   stall;
    int   d0;
    int   t;
    bit   drained;
    bit   r;
    row = 0; stall = 0; drained = 1'b0; done_c = -1;
    d0 = k + 2 + FLUSH_N;
    check($sformatf("k%0d_idle_pre", k), 64'(sample()), 64'(idle_obs()));
    bus.start = 1'b1;
    bus.k_len = K_W'(k);
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.k_len = K_W'($urandom);
      e = '0;
      if (c == 1) e.mac_clr = 1'b1;
      else if (c <= k + 1) begin
        e.rd_en   = 1'b1;
        e.rd_addr = K_W'(c - 2);
      end else if (c >= d0 && !drained) begin
        e.ov  = 1'b1;
        e.row = ROW_W'(row);
      end else if (drained) e.done = 1'b1;
      for (int d = 0; d < NDIAG; d++) begin
        t = c - RD_LAT - d;
        e.diag[d] = (t >= 2) && (t <= k + 1);
      end
      check($sformatf("k%0d_c%0d", k, c), 64'(sample()), 64'(e));
      if (e.done) begin
        done_c = c;
        break;
      end
      if (e.ov) begin
        if (row == stall_row && stall < 5) begin
          r = 1'b0;
          stall++;
        end else r = ($urandom_range(1, 100) <= rdy_pct);
        bus.out_ready = r;
        if (r) begin
          row++;
          if (row == ROWS) drained = 1'b1;
        end
      end else bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (done_c < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL k%0d_timeout: got no done expected done", k);
    end
    bus.start = 1'b0;
    @(negedge clk);
`ifdef SA_TILE_CTRL_PERF_EN
    check($sformatf("k%0d_perf", k), 64'(perf_cycles), 64'(done_c));
`endif
  endtask

  vec_t vecs[5];
  int   dc;
  int   dones;

  initial begin
    vecs[0] = '{k: 8,   exp_done: 22};
    vecs[1] = '{k: 0,   exp_done: 14};
    vecs[2] = '{k: 1,   exp_done: 15};
    vecs[3] = '{k: 3,   exp_done: 17};
    vecs[4] = '{k: 255, exp_done: 269};

    bus.start = 1'b0;
    bus.k_len = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(sample()), 64'(idle_obs()));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'(sample()), 64'(idle_obs()));

    // Table vectors: full trace check plus the accept-to-done cycle
    foreach (vecs[i]) begin
      run_pass(vecs[i].k, 100, -1, 1'b0, dc);
      check($sformatf("done_cyc_k%0d", vecs[i].k), 64'(dc), 64'(vecs[i].exp_done));
`ifdef SA_TILE_CTRL_PERF_EN
      if (i == 0) begin
        repeat (3) @(negedge clk);
        check("perf_hold", 64'(perf_cycles), 64'(22));
      end
`endif
    end

    // Backpressure: five stalled cycles while row 2 is presented
    run_pass(3, 100, 2, 1'b0, dc);
    check("done_cyc_stall", 64'(dc), 64'(22));

    // Start pulses during the pass must be ignored.
    // Back-to-back passes are accepted in the cycle after done.
    run_pass(5, 100, -1, 1'b1, dc);
    check("done_cyc_noise", 64'(dc), 64'(19));
    run_pass(2, 100, -1, 1'b1, dc);
    check("done_cyc_b2b", 64'(dc), 64'(16));

    // Reset during FEED cycle 4 abandons the pass
    bus.start = 1'b1;
    bus.k_len = K_W'(8);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_feed_addr", 64'({bus.rd_en, bus.rd_addr}), 64'({1'b1, K_W'(3)}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_idle", 64'(sample()), 64'(idle_obs()));
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done || !bus.ready) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'(0));
    run_pass(2, 100, -1, 1'b0, dc);
    check("done_cyc_after_reset", 64'(dc), 64'(16));

    // Randomized passes against the timeline model
    for (int p = 0; p < 15; p++) begin
      run_pass(int'($urandom_range(0, 20)), int'($urandom_range(30, 100)), -1,
               1'($urandom_range(0, 1)), dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
